// File: rtl/edl_peak_pkg.sv
// edl_peak_pkg: shared constants for the peak capture sequencer.
// FSM state codes, register word addresses and CTRL/STATUS bit positions.
package edl_peak_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_WINDOW  = 3'd2;
  localparam logic [2:0] A_THRESH  = 3'd3;
  localparam logic [2:0] A_PEAK    = 3'd4;
  localparam logic [2:0] A_PIDX    = 3'd5;
  localparam logic [2:0] A_COUNT   = 3'd6;

  localparam int C_START  = 0;
  localparam int C_ABORT  = 1;
  localparam int C_IRQ_EN = 2;
  localparam int C_CONT   = 3;

  localparam int ST_DONE  = 1;
  localparam int ST_OVR   = 2;

endpackage

// File: rtl/edl_peak_tracker.sv
// edl_peak_tracker: running maximum, first-occurrence index and
// sample counter for one capture window.
module edl_peak_tracker
  import edl_peak_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WIN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] peak,
  output logic [WIN_W-1:0]  idx,
  output logic [WIN_W-1:0]  count
);

  // Trigger sample seeds the window as index 0; later samples only
  // replace the peak when strictly larger, so ties keep the first.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      peak  <= '0;
      idx   <= '0;
      count <= '0;
    end else if (load) begin
      peak  <= sample;
      idx   <= '0;
      count <= WIN_W'(1);
    end else if (en) begin
      if (sample > peak) begin
        peak <= sample;
        idx  <= count;
      end
      count <= count + WIN_W'(1);
    end
  end

endmodule

// File: rtl/edl_peak_capture_ctrl.sv
// edl_peak_capture_ctrl: Avalon-MM armed peak capture sequencer.
// Waits for a threshold trigger, tracks max over a window, latches, IRQs.
module edl_peak_capture_ctrl
  import edl_peak_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WIN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              irq
);

  logic [1:0]        state;
  logic [1:0]        state_d;
  logic              irq_en;
  logic              cont;
  logic              done;
  logic              ovr;
  logic [WIN_W-1:0]  window;
  logic [WIN_W-1:0]  win_eff;
  logic [DATA_W-1:0] thresh;
  logic [DATA_W-1:0] peak_q;
  logic [WIN_W-1:0]  idx_q;
  logic [DATA_W-1:0] trk_peak;
  logic [WIN_W-1:0]  trk_idx;
  logic [WIN_W-1:0]  trk_cnt;
  logic [WIN_W:0]    cnt_nxt;
  logic              trk_clr;
  logic              trk_load;
  logic              trk_en;
  logic              wr;
  logic              wr_ctrl;
  logic              wr_stat;
  logic              wr_win;
  logic              wr_thr;
  logic              start;
  logic              abort;
  logic              trig;
  logic              win_hit;
  logic              latch;
  logic              busy;
  logic [31:0]       rd_mux;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr & (address == A_CTRL);
  assign wr_stat = wr & (address == A_STATUS);
  assign wr_win  = wr & (address == A_WINDOW);
  assign wr_thr  = wr & (address == A_THRESH);
  assign start   = wr_ctrl & writedata[C_START];
  assign abort   = wr_ctrl & writedata[C_ABORT];

  assign win_eff = (window == '0) ? WIN_W'(1) : window;
  assign trig    = sample_valid & (sample_data >= thresh);
  assign cnt_nxt = {1'b0, trk_cnt} + (WIN_W+1)'(1);
  assign win_hit = cnt_nxt >= {1'b0, win_eff};
  assign latch   = (state == S_DONE) & ~abort;
  assign busy    = state != S_IDLE;
  assign irq     = done & irq_en;

  // Next state and tracker control; abort overrides every state.
  always_comb begin
    state_d  = state;
    trk_clr  = 1'b0;
    trk_load = 1'b0;
    trk_en   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_d = S_ARMED;
            trk_clr = 1'b1;
          end
        end
        S_ARMED: begin
          if (trig) begin
            trk_load = 1'b1;
            state_d  = (win_eff == WIN_W'(1)) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            trk_en = 1'b1;
            if (win_hit) state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = cont ? S_ARMED : S_IDLE;
          trk_clr = cont;
        end
      endcase
    end
  end

  edl_peak_tracker #(
    .DATA_W (DATA_W),
    .WIN_W  (WIN_W)
  ) u_trk (
    .clk    (clk),
    .reset  (reset),
    .clr    (trk_clr),
    .load   (trk_load),
    .en     (trk_en),
    .sample (sample_data),
    .peak   (trk_peak),
    .idx    (trk_idx),
    .count  (trk_cnt)
  );

  // Read mux, sampled into readdata every cycle.
  always_comb begin
    rd_mux = '0;
    case (address)
      A_CTRL:   rd_mux = {28'd0, cont, irq_en, 2'd0};
      A_STATUS: rd_mux = {26'd0, state, 1'b0, ovr, done, busy};
      A_WINDOW: rd_mux = 32'(window);
      A_THRESH: rd_mux = 32'(thresh);
      A_PEAK:   rd_mux = 32'(peak_q);
      A_PIDX:   rd_mux = 32'(idx_q);
      A_COUNT:  rd_mux = 32'(trk_cnt);
      default:  rd_mux = '0;
    endcase
  end

  // FSM state, software registers and result latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      irq_en   <= 1'b0;
      cont     <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      window   <= '0;
      thresh   <= '0;
      peak_q   <= '0;
      idx_q    <= '0;
      readdata <= '0;
    end else begin
      state    <= state_d;
      readdata <= rd_mux;
      if (wr_ctrl) begin
        irq_en <= writedata[C_IRQ_EN];
        cont   <= writedata[C_CONT];
      end
      if (wr_win) window <= writedata[WIN_W-1:0];
      if (wr_thr) thresh <= writedata[DATA_W-1:0];
      if (wr_stat && writedata[ST_DONE]) done <= 1'b0;
      if (wr_stat && writedata[ST_OVR])  ovr  <= 1'b0;
      if (latch) begin
        peak_q <= trk_peak;
        idx_q  <= trk_idx;
        done   <= 1'b1;
        if (done) ovr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_edl_peak_capture_ctrl.sv
// tb_edl_peak_capture_ctrl: directed plus random stimulus against a
// queue-based model of the capture sequencer.
module tb_edl_peak_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  edl_peak_capture_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 waiting for trigger, 2 collecting, 3 finishing.
  // The window's samples are kept in a queue and reduced at the end.
  int          m_ph = 0;
  logic [31:0] m_win = '0, m_thr = '0, m_peak = '0, m_idx = '0;
  bit          m_ien = 0, m_cont = 0, m_done = 0, m_ovr = 0;
  logic [31:0] m_q[$];
  logic [31:0] exp_rd = '0;
  bit          exp_irq = 0;

  function automatic logic [31:0] m_view(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_cont, m_ien, 2'd0};
      3'd1: return {26'd0, 2'(m_ph), 1'b0, m_ovr, m_done, 1'(m_ph != 0)};
      3'd2: return m_win;
      3'd3: return m_thr;
      3'd4: return m_peak;
      3'd5: return m_idx;
      3'd6: return 32'(m_q.size());
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step();
    bit wr, st, ab, od, fin;
    int eff, nph;
    logic [31:0] pk;
    int ix;
    exp_rd = m_view(address);
    if (reset) begin
      exp_rd = '0;
      m_ph = 0; m_win = '0; m_thr = '0; m_peak = '0; m_idx = '0;
      m_ien = 0; m_cont = 0; m_done = 0; m_ovr = 0;
      m_q.delete();
    end else begin
      wr  = chipselect && !write_n;
      st  = wr && address == 3'd0 && writedata[0];
      ab  = wr && address == 3'd0 && writedata[1];
      eff = (m_win == 0) ? 1 : int'(m_win);
      od  = m_done;
      nph = m_ph;
      fin = 0;
      if (ab) nph = 0;
      else case (m_ph)
        0: if (st) begin m_q.delete(); nph = 1; end
        1: if (sample_valid && sample_data >= m_thr) begin
             m_q.delete();
             m_q.push_back(sample_data);
             nph = (m_q.size() >= eff) ? 3 : 2;
           end
        2: if (sample_valid) begin
             m_q.push_back(sample_data);
             if (m_q.size() >= eff) nph = 3;
           end
        default: begin fin = 1; nph = m_cont ? 1 : 0; end
      endcase
      if (fin) begin
        pk = m_q[0]; ix = 0;
        foreach (m_q[i]) if (m_q[i] > pk) begin pk = m_q[i]; ix = i; end
        m_peak = pk;
        m_idx  = 32'(ix);
        if (m_cont) m_q.delete();
      end
      if (wr) case (address)
        3'd0: begin m_ien = writedata[2]; m_cont = writedata[3]; end
        3'd1: begin
          if (writedata[1]) m_done = 0;
          if (writedata[2]) m_ovr = 0;
        end
        3'd2: m_win = {16'd0, writedata[15:0]};
        3'd3: m_thr = writedata;
        default: ;
      endcase
      if (fin) begin
        m_done = 1;
        if (od) m_ovr = 1;
      end
      m_ph = nph;
    end
    exp_irq = m_done && m_ien;
  endtask

  // Per-cycle compare of readdata and irq against the model.
  always begin
    @(posedge clk);
    m_step();
    #1;
    check("readdata", readdata, exp_rd);
    check("irq", 32'(irq), 32'(exp_irq));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'($urandom_range(0, 7));
    sample_valid = v; sample_data = d;
  endtask

  task automatic wreg_s(input logic [2:0] a, input logic [31:0] d,
                        input logic v, input logic [31:0] sd);
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b1; write_n = 1'b0;
    address = a; writedata = d;
    sample_valid = v; sample_data = sd;
  endtask

  task automatic wreg(input logic [2:0] a, input logic [31:0] d);
    wreg_s(a, d, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0);
  endtask

  task automatic rdchk(input string nm, input logic [2:0] a,
                       input logic [31:0] exp);
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = a; sample_valid = 1'b0;
    @(posedge clk);
    #1;
    check(nm, readdata, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    rdchk("reset_status", 3'd1, 32'd0);

    // basic window, start-cycle sample ignored
    wreg(3'd2, 32'd4);
    wreg(3'd3, 32'd10);
    wreg_s(3'd0, 32'h1, 1'b1, 32'd99);
    drive(1'b1, 32'd5);
    drive(1'b1, 32'd12);
    drive(1'b1, 32'd30);
    drive(1'b1, 32'd7);
    drive(1'b1, 32'd30);
    idle(3);
    rdchk("basic_peak", 3'd4, 32'd30);
    rdchk("basic_idx", 3'd5, 32'd1);
    rdchk("basic_status", 3'd1, 32'h2);
    rdchk("basic_count", 3'd6, 32'd4);

    // irq assert and W1C
    wreg(3'd1, 32'h2);
    wreg(3'd0, 32'h5);
    drive(1'b1, 32'd20);
    drive(1'b1, 32'd1);
    drive(1'b1, 32'd2);
    drive(1'b1, 32'd3);
    idle(2);
    check("irq_set", 32'(irq), 32'd1);
    wreg(3'd1, 32'h2);
    check("irq_hold", 32'(irq), 32'd1);
    idle(1);
    check("irq_clr", 32'(irq), 32'd0);
    rdchk("irq_status", 3'd1, 32'h0);
    rdchk("irq_peak", 3'd4, 32'd20);

    // continuous, three windows, overrun
    wreg(3'd2, 32'd2);
    wreg(3'd0, 32'h9);
    drive(1'b1, 32'd15); drive(1'b1, 32'd40); idle(1);
    drive(1'b1, 32'd50); drive(1'b1, 32'd11); idle(1);
    drive(1'b1, 32'd12); drive(1'b1, 32'd60); idle(1);
    rdchk("cont_peak", 3'd4, 32'd60);
    rdchk("cont_idx", 3'd5, 32'd1);
    rdchk("cont_status", 3'd1, 32'h17);
    wreg(3'd0, 32'h2);
    rdchk("cont_abort", 3'd1, 32'h6);

    // abort mid capture, start+abort together
    wreg(3'd2, 32'd5);
    wreg(3'd0, 32'h1);
    drive(1'b1, 32'd20);
    drive(1'b1, 32'd30);
    wreg(3'd0, 32'h2);
    rdchk("abort_status", 3'd1, 32'h6);
    rdchk("abort_peak", 3'd4, 32'd60);
    rdchk("abort_count", 3'd6, 32'd2);
    wreg(3'd0, 32'h3);
    rdchk("startabort", 3'd1, 32'h6);

    // zero window = single sample, valid gaps
    wreg(3'd1, 32'h6);
    wreg(3'd2, 32'd0);
    wreg(3'd0, 32'h1);
    drive(1'b1, 32'd3);
    drive(1'b0, 32'd50);
    drive(1'b1, 32'd77);
    drive(1'b1, 32'd99);
    idle(2);
    rdchk("w0_peak", 3'd4, 32'd77);
    rdchk("w0_idx", 3'd5, 32'd0);
    rdchk("w0_status", 3'd1, 32'h2);
    rdchk("w0_count", 3'd6, 32'd1);

    // reset mid capture
    wreg(3'd2, 32'd10);
    wreg(3'd0, 32'h5);
    drive(1'b1, 32'd20);
    drive(1'b1, 32'd30);
    check("pre_rst_irq", 32'(irq), 32'd1);
    @(negedge clk);
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    sample_valid = 1'b1; sample_data = 32'd90; address = 3'd4;
    @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rdchk("rst_status", 3'd1, 32'd0);
    rdchk("rst_peak", 3'd4, 32'd0);
    rdchk("rst_window", 3'd2, 32'd0);
    rdchk("rst_thresh", 3'd3, 32'd0);
    rdchk("rst_ctrl", 3'd0, 32'd0);

    // randomized traffic, model-checked every cycle
    wreg(3'd3, 32'd20);
    wreg(3'd2, 32'd3);
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      logic [31:0] wd;
      r = $urandom_range(0, 199);
      if (r < 130) begin
        drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)));
      end else if (r < 145) begin
        wreg(3'd3, 32'($urandom_range(0, 63)));
      end else if (r < 155) begin
        wreg(3'd2, 32'($urandom_range(0, 6)));
      end else if (r < 180) begin
        wd = $urandom;
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[1] = ($urandom_range(0, 9) == 0);
        wreg_s(3'd0, wd, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 63)));
      end else if (r < 192) begin
        wreg_s(3'd1, $urandom, 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 63)));
      end else if (r < 198) begin
        wreg(3'($urandom_range(4, 7)), $urandom);
      end else begin
        @(negedge clk);
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        sample_valid = 1'b0;
      end
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
